// File: rtl/arm_timer_pkg.sv
// Shared constants for the ARM compare timer: register map, bit positions,
// access-select codes and handshake FSM encoding.
package arm_timer_pkg;

  // Word-aligned byte addresses of the register map
  localparam int unsigned ADDR_CTRL   = 'h00;
  localparam int unsigned ADDR_CMP    = 'h04;
  localparam int unsigned ADDR_PERIOD = 'h08;
  localparam int unsigned ADDR_STATUS = 'h0C;
  localparam int unsigned ADDR_NOW    = 'h10;

  // CTRL bit indices
  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_W        = 3;

  // STATUS bit indices
  localparam int unsigned STATUS_PENDING = 0;
  localparam int unsigned STATUS_OVERRUN = 1;

  // Decoded register select handed from the register interface to the core
  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_NONE   = 3'd0;
  localparam logic [SEL_W-1:0] SEL_CTRL   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_CMP    = 3'd2;
  localparam logic [SEL_W-1:0] SEL_PERIOD = 3'd3;
  localparam logic [SEL_W-1:0] SEL_STATUS = 3'd4;
  localparam logic [SEL_W-1:0] SEL_NOW    = 3'd5;

  // Register-port handshake states
  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } regif_state_e;

endpackage

// File: rtl/arm_timer_regif.sv
// Register-port front end: valid/ready request handshake with a single
// outstanding access, address decode, write strobe and response register.
module arm_timer_regif
  import arm_timer_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              cnt_clk,
  input  logic              cnt_reset,
  input  logic              reg_req_valid,
  output logic              reg_req_ready,
  input  logic              reg_req_wr,
  input  logic [ADDR_W-1:0] reg_req_addr,
  input  logic [CNT_W-1:0]  reg_req_wdata,
  output logic              reg_resp_valid,
  input  logic              reg_resp_ready,
  output logic [CNT_W-1:0]  reg_resp_rdata,
  output logic              acc_wr_en,
  output logic [SEL_W-1:0]  acc_sel,
  output logic [CNT_W-1:0]  acc_wdata,
  input  logic [CNT_W-1:0]  acc_rdata
);

  regif_state_e      state_q, state_d;
  logic [CNT_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0] word_addr;
  logic              accept;
  logic              unused_addr_lsb;

  // Byte offset within a word carries no meaning
  assign word_addr       = {reg_req_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^reg_req_addr[1:0];

  assign accept    = reg_req_valid & (state_q == ST_IDLE);
  assign acc_wr_en = accept & reg_req_wr;
  assign acc_wdata = reg_req_wdata;

  // Address decode into a register select, shared by the write strobe and read mux
  always_comb begin
    acc_sel = SEL_NONE;
    case (word_addr)
      ADDR_W'(ADDR_CTRL):   acc_sel = SEL_CTRL;
      ADDR_W'(ADDR_CMP):    acc_sel = SEL_CMP;
      ADDR_W'(ADDR_PERIOD): acc_sel = SEL_PERIOD;
      ADDR_W'(ADDR_STATUS): acc_sel = SEL_STATUS;
      ADDR_W'(ADDR_NOW):    acc_sel = SEL_NOW;
      default:              acc_sel = SEL_NONE;
    endcase
  end

  // Handshake state register
  always_ff @(posedge cnt_clk) begin
    if (cnt_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, hold response until the consumer takes it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)         state_d = ST_RESP;
      ST_RESP: if (reg_resp_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    reg_req_ready  = 1'b0;
    reg_resp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: reg_req_ready  = 1'b1;
      ST_RESP: reg_resp_valid = 1'b1;
      default: reg_req_ready  = 1'b0;
    endcase
  end

  // Read data captured at acceptance so it stays stable while held; writes return 0
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = reg_req_wr ? '0 : acc_rdata;
    end
  end

  // Response data register
  always_ff @(posedge cnt_clk) begin
    if (cnt_reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign reg_resp_rdata = rdata_q;

endmodule

// File: rtl/arm_counter_timer_irq.sv
// Compare timer on the free-running microsecond count: one-shot and periodic
// deadlines, pending/overrun status and a level interrupt.
module arm_counter_timer_irq
  import arm_timer_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              cnt_clk,
  input  logic              cnt_reset,
  input  logic [CNT_W-1:0]  cnt_value,
  input  logic              reg_req_valid,
  output logic              reg_req_ready,
  input  logic              reg_req_wr,
  input  logic [ADDR_W-1:0] reg_req_addr,
  input  logic [CNT_W-1:0]  reg_req_wdata,
  output logic              reg_resp_valid,
  input  logic              reg_resp_ready,
  output logic [CNT_W-1:0]  reg_resp_rdata,
  output logic              irq
);

  logic              acc_wr_en;
  logic [SEL_W-1:0]  acc_sel;
  logic [CNT_W-1:0]  acc_wdata;
  logic [CNT_W-1:0]  acc_rdata;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;

  logic [CNT_W-1:0]  diff;
  logic              due;
  logic              reload;
  logic              unused_diff;
  logic              wr_ctrl, wr_cmp, wr_period, wr_status;

  arm_timer_regif #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_regif (
    .cnt_clk        (cnt_clk),
    .cnt_reset      (cnt_reset),
    .reg_req_valid  (reg_req_valid),
    .reg_req_ready  (reg_req_ready),
    .reg_req_wr     (reg_req_wr),
    .reg_req_addr   (reg_req_addr),
    .reg_req_wdata  (reg_req_wdata),
    .reg_resp_valid (reg_resp_valid),
    .reg_resp_ready (reg_resp_ready),
    .reg_resp_rdata (reg_resp_rdata),
    .acc_wr_en      (acc_wr_en),
    .acc_sel        (acc_sel),
    .acc_wdata      (acc_wdata),
    .acc_rdata      (acc_rdata)
  );

  // Deadline reached when (now - cmp) is non-negative as a signed half-range value
  assign diff        = cnt_value - cmp_q;
  assign due         = ctrl_q[CTRL_ENABLE] & ~diff[CNT_W-1];
  assign reload      = ctrl_q[CTRL_PERIODIC] & (period_q != '0);
  assign unused_diff = ^diff[CNT_W-2:0];

  assign wr_ctrl   = acc_wr_en & (acc_sel == SEL_CTRL);
  assign wr_cmp    = acc_wr_en & (acc_sel == SEL_CMP);
  assign wr_period = acc_wr_en & (acc_sel == SEL_PERIOD);
  assign wr_status = acc_wr_en & (acc_sel == SEL_STATUS);

  // Read mux, sampled by the register interface at acceptance
  always_comb begin
    acc_rdata = '0;
    case (acc_sel)
      SEL_CTRL:   acc_rdata = {{(CNT_W-CTRL_W){1'b0}}, ctrl_q};
      SEL_CMP:    acc_rdata = cmp_q;
      SEL_PERIOD: acc_rdata = period_q;
      SEL_STATUS: acc_rdata = {{(CNT_W-2){1'b0}}, overrun_q, pending_q};
      SEL_NOW:    acc_rdata = cnt_value;
      default:    acc_rdata = '0;
    endcase
  end

  // Timer next state: fire effects first, then software writes override
  always_comb begin
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    period_d  = period_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (due) begin
      if (reload) begin
        cmp_d = cmp_q + period_q;
      end else begin
        ctrl_d[CTRL_ENABLE] = 1'b0;
      end
    end

    if (wr_ctrl)   ctrl_d   = acc_wdata[CTRL_W-1:0];
    if (wr_cmp)    cmp_d    = acc_wdata;
    if (wr_period) period_d = acc_wdata;

    if (wr_status) begin
      if (acc_wdata[STATUS_PENDING]) pending_d = 1'b0;
      if (acc_wdata[STATUS_OVERRUN]) overrun_d = 1'b0;
    end

    // A fire beats a same-cycle clear
    if (due) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
  end

  // Timer register state
  always_ff @(posedge cnt_clk) begin
    if (cnt_reset) begin
      ctrl_q    <= '0;
      cmp_q     <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq = pending_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_arm_counter_timer_irq.sv
// Self-checking bench for the ARM compare timer: reset values, handshake
// timing, one-shot, periodic, wrap, fire/clear collision and mid-access reset.
module tb_arm_counter_timer_irq;

  logic        cnt_clk = 1'b0;
  logic        cnt_reset;
  logic [31:0] cnt_value;
  logic        reg_req_valid;
  logic        reg_req_ready;
  logic        reg_req_wr;
  logic [4:0]  reg_req_addr;
  logic [31:0] reg_req_wdata;
  logic        reg_resp_valid;
  logic        reg_resp_ready;
  logic [31:0] reg_resp_rdata;
  logic        irq;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 cnt_clk = ~cnt_clk;

  arm_counter_timer_irq #(
    .ADDR_W (5),
    .CNT_W  (32)
  ) dut (
    .cnt_clk        (cnt_clk),
    .cnt_reset      (cnt_reset),
    .cnt_value      (cnt_value),
    .reg_req_valid  (reg_req_valid),
    .reg_req_ready  (reg_req_ready),
    .reg_req_wr     (reg_req_wr),
    .reg_req_addr   (reg_req_addr),
    .reg_req_wdata  (reg_req_wdata),
    .reg_resp_valid (reg_resp_valid),
    .reg_resp_ready (reg_resp_ready),
    .reg_resp_rdata (reg_resp_rdata),
    .irq            (irq)
  );

  task automatic step();
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic do_reset();
    cnt_reset = 1'b1;
    step();
    step();
    cnt_reset = 1'b0;
  endtask

  // One full access; on_time reports a response exactly one cycle after acceptance
  task automatic bus_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic on_time);
    int waitc = 0;
    reg_req_valid  = 1'b1;
    reg_req_wr     = wr;
    reg_req_addr   = addr;
    reg_req_wdata  = wdata;
    reg_resp_ready = 1'b1;
    while (!reg_req_ready && waitc < 20) begin
      step();
      waitc++;
    end
    if (!reg_req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bus_req_timeout addr=%h: ready=%b, required 1", addr, reg_req_ready);
      reg_req_valid = 1'b0;
      rdata   = '0;
      on_time = 1'b0;
      return;
    end
    step();
    reg_req_valid = 1'b0;
    on_time = reg_resp_valid;
    waitc = 0;
    while (!reg_resp_valid && waitc < 20) begin
      step();
      waitc++;
    end
    if (!reg_resp_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL bus_resp_timeout addr=%h: resp_valid=%b, required 1", addr, reg_resp_valid);
    end
    rdata = reg_resp_rdata;
    step();
  endtask

  task automatic bus_wr(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        ot;
    bus_xfer(1'b1, addr, wdata, rd, ot);
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [4] = '{5'h00, 5'h04, 5'h0C, 5'h10};
    logic [31:0] exps  [4] = '{32'h0, 32'h0, 32'h0, 32'h1234};
    logic [31:0] rd, ev;
    logic        ot;
    cnt_value = 32'h1234;
    do_reset();
    n_cmp++;
    if (reg_req_ready !== 1'b1 || reg_resp_valid !== 1'b0 || reg_resp_rdata !== 32'h0 ||
        irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h irq=%b, required 1 0 0 0",
               reg_req_ready, reg_resp_valid, reg_resp_rdata, irq);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      bus_xfer(1'b0, addrs[i], 32'h0, rd, ot);
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd !== ev) begin
        n_fail++;
        $display("FAIL reset_read addr=%h: got %h, required %h", addrs[i], rd, ev);
      end
      n_cmp++;
      if (ot !== 1'b1) begin
        n_fail++;
        $display("FAIL resp_latency addr=%h: on_time=%b, required 1", addrs[i], ot);
      end
    end
    // Response held by backpressure: no new request accepted, data stable
    exp_q.push_back(32'h1234);
    reg_req_valid  = 1'b1;
    reg_req_wr     = 1'b0;
    reg_req_addr   = 5'h12;
    reg_resp_ready = 1'b0;
    step();
    reg_req_valid = 1'b0;
    ev = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (reg_req_ready !== 1'b0 || reg_resp_valid !== 1'b1 || reg_resp_rdata !== ev) begin
        n_fail++;
        $display("FAIL resp_hold cycle %0d: ready=%b valid=%b rdata=%h, required 0 1 %h",
                 i, reg_req_ready, reg_resp_valid, reg_resp_rdata, ev);
      end
      step();
    end
    reg_resp_ready = 1'b1;
    step();
    n_cmp++;
    if (reg_req_ready !== 1'b1 || reg_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_release: ready=%b valid=%b, required 1 0",
               reg_req_ready, reg_resp_valid);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd, ev;
    logic        ot;
    logic        exp_irq;
    do_reset();
    cnt_value = 32'd98;
    bus_wr(5'h04, 32'd100);
    bus_wr(5'h00, 32'h5);
    for (int v = 98; v <= 102; v++) begin
      cnt_value = 32'(v);
      step();
      exp_irq = (v >= 100);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL oneshot_irq cnt=%0d: got %b, required %b", v, irq, exp_irq);
      end
    end
    exp_q.push_back(32'h4);
    bus_xfer(1'b0, 5'h00, 32'h0, rd, ot);
    ev = exp_q.pop_front();
    n_cmp++;
    if (rd !== ev) begin
      n_fail++;
      $display("FAIL oneshot_ctrl: got %h, required %h", rd, ev);
    end
    exp_q.push_back(32'h1);
    bus_xfer(1'b0, 5'h0C, 32'h0, rd, ot);
    ev = exp_q.pop_front();
    n_cmp++;
    if (rd !== ev) begin
      n_fail++;
      $display("FAIL oneshot_status: got %h, required %h", rd, ev);
    end
  endtask

  task automatic test_periodic();
    logic [4:0]  addrs [3] = '{5'h04, 5'h0C, 5'h0C};
    logic [31:0] exps  [3] = '{32'd20, 32'h3, 32'h0};
    logic [31:0] rd, ev;
    logic        ot;
    logic        exp_irq;
    do_reset();
    cnt_value = 32'd0;
    bus_wr(5'h04, 32'd10);
    bus_wr(5'h08, 32'd5);
    bus_wr(5'h00, 32'h7);
    for (int v = 8; v <= 17; v++) begin
      cnt_value = 32'(v);
      step();
      exp_irq = (v >= 10);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL periodic_irq cnt=%0d: got %b, required %b", v, irq, exp_irq);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus_wr(5'h0C, 32'h3);
      exp_q.push_back(exps[i]);
      bus_xfer(1'b0, addrs[i], 32'h0, rd, ot);
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd !== ev) begin
        n_fail++;
        $display("FAIL periodic_read %0d addr=%h: got %h, required %h", i, addrs[i], rd, ev);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic_irq_cleared: got %b, required 0", irq);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] vals [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1,
                              32'h2, 32'h3, 32'h4, 32'h5};
    logic exp_irq;
    do_reset();
    cnt_value = 32'hFFFF_FFFE;
    bus_wr(5'h04, 32'h4);
    bus_wr(5'h00, 32'h5);
    for (int i = 0; i < 8; i++) begin
      cnt_value = vals[i];
      step();
      exp_irq = (i >= 6);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL wrap_irq cnt=%h: got %b, required %b", vals[i], irq, exp_irq);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd, ev;
    logic        ot;
    do_reset();
    cnt_value = 32'd0;
    bus_wr(5'h04, 32'd50);
    bus_wr(5'h08, 32'd10);
    bus_wr(5'h00, 32'h7);
    cnt_value = 32'd50;
    step();
    // Clear lands on the very edge the reloaded deadline (60) is reached
    cnt_value = 32'd60;
    bus_wr(5'h0C, 32'h3);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_irq: got %b, required 1", irq);
    end
    exp_q.push_back(32'h3);
    bus_xfer(1'b0, 5'h0C, 32'h0, rd, ot);
    ev = exp_q.pop_front();
    n_cmp++;
    if (rd !== ev) begin
      n_fail++;
      $display("FAIL collision_status: got %h, required %h", rd, ev);
    end
    exp_q.push_back(32'd70);
    bus_xfer(1'b0, 5'h04, 32'h0, rd, ot);
    ev = exp_q.pop_front();
    n_cmp++;
    if (rd !== ev) begin
      n_fail++;
      $display("FAIL collision_cmp: got %h, required %h", rd, ev);
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [4:0]  addrs [4] = '{5'h00, 5'h04, 5'h08, 5'h0C};
    logic [31:0] rd, ev;
    logic        ot;
    do_reset();
    cnt_value = 32'd0;
    bus_wr(5'h04, 32'd123);
    bus_wr(5'h08, 32'd7);
    bus_wr(5'h00, 32'h5);
    cnt_value = 32'd200;
    step();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre_irq: got %b, required 1", irq);
    end
    reg_req_valid  = 1'b1;
    reg_req_wr     = 1'b0;
    reg_req_addr   = 5'h04;
    reg_resp_ready = 1'b0;
    step();
    reg_req_valid = 1'b0;
    step();
    cnt_reset = 1'b1;
    step();
    cnt_reset = 1'b0;
    n_cmp++;
    if (reg_resp_valid !== 1'b0 || reg_req_ready !== 1'b1 || reg_resp_rdata !== 32'h0 ||
        irq !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b ready=%b rdata=%h irq=%b, required 0 1 0 0",
               reg_resp_valid, reg_req_ready, reg_resp_rdata, irq);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      bus_xfer(1'b0, addrs[i], 32'h0, rd, ot);
      ev = exp_q.pop_front();
      n_cmp++;
      if (rd !== ev) begin
        n_fail++;
        $display("FAIL midreset_read addr=%h: got %h, required %h", addrs[i], rd, ev);
      end
    end
  endtask

  initial begin
    cnt_reset      = 1'b1;
    cnt_value      = '0;
    reg_req_valid  = 1'b0;
    reg_req_wr     = 1'b0;
    reg_req_addr   = '0;
    reg_req_wdata  = '0;
    reg_resp_ready = 1'b1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_collision();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
